// File: rtl/ica_unmix.sv
// FastICA source-separation stage: captures the 4x4 demixing matrix W on convergence
// and streams whitened samples z through four row-parallel MACs, producing y = W*z.
module ica_unmix #(
   parameter int DW   = 26,
   parameter int FRAC = 20
)(
   input  logic                 clk_unmix,
   input  logic                 rstn_unmix,
   input  logic                 w_load,
   input  logic                 isConverge,
   input  logic signed [DW-1:0] w11, w12, w13, w14,
   input  logic signed [DW-1:0] w21, w22, w23, w24,
   input  logic signed [DW-1:0] w31, w32, w33, w34,
   input  logic signed [DW-1:0] w41, w42, w43, w44,
   input  logic                 z_valid,
   output logic                 z_ready,
   input  logic signed [DW-1:0] z1, z2, z3, z4,
   output logic                 y_valid,
   input  logic                 y_ready,
   output logic signed [DW-1:0] y1, y2, y3, y4,
   output logic                 w_loaded,
   output logic                 unmix_busy,
   output logic                 sat_flag
);

   localparam int AW = 2*DW + 2;
   localparam logic signed [AW-1:0] RND  = AW'(1) << (FRAC-1);
   localparam logic signed [AW-1:0] YMAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [AW-1:0] YMIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {EMPTY, READY, MAC, OUT} state_t;

   state_t               state;
   logic [2:0]           k;
   logic signed [DW-1:0] w_in  [4][4];
   logic signed [DW-1:0] w_reg [4][4];
   logic signed [DW-1:0] z_in  [4];
   logic signed [DW-1:0] z_reg [4];
   logic signed [DW-1:0] y_reg [4];
   logic signed [DW-1:0] y_next[4];
   logic signed [AW-1:0] acc   [4];
   logic signed [AW-1:0] rnd   [4];
   logic signed [AW-1:0] shifted[4];
   logic signed [2*DW-1:0] prod[4];
   logic [3:0]           clamp;
   logic                 capture;

   assign w_in = '{'{w11, w12, w13, w14},
                   '{w21, w22, w23, w24},
                   '{w31, w32, w33, w34},
                   '{w41, w42, w43, w44}};
   assign z_in = '{z1, z2, z3, z4};

   assign capture    = w_load && isConverge && (state == EMPTY || state == READY);
   assign z_ready    = (state == READY);
   assign unmix_busy = (state == MAC) || (state == OUT);
   assign y1 = y_reg[0];
   assign y2 = y_reg[1];
   assign y3 = y_reg[2];
   assign y4 = y_reg[3];

   // Column k of W times z_k for every row, plus round-half-up and clamp of the finished sums.
   always_comb begin
      clamp = '0;
      for (int i = 0; i < 4; i++) begin
         prod[i]    = (2*DW)'(w_reg[i][k[1:0]]) * (2*DW)'(z_reg[k[1:0]]);
         rnd[i]     = acc[i] + RND;
         shifted[i] = rnd[i] >>> FRAC;
         y_next[i]  = shifted[i][DW-1:0];
         if (shifted[i] > YMAX) begin
            y_next[i] = YMAX[DW-1:0];
            clamp[i]  = 1'b1;
         end else if (shifted[i] < YMIN) begin
            y_next[i] = YMIN[DW-1:0];
            clamp[i]  = 1'b1;
         end
      end
   end

   // Main sequencer: k counts four MAC edges, the fifth MAC-state edge forms the output.
   always_ff @(posedge clk_unmix or negedge rstn_unmix) begin
      if (!rstn_unmix) begin
         state    <= EMPTY;
         k        <= '0;
         y_valid  <= 1'b0;
         w_loaded <= 1'b0;
         sat_flag <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            z_reg[i] <= '0;
            y_reg[i] <= '0;
            acc[i]   <= '0;
            for (int j = 0; j < 4; j++) w_reg[i][j] <= '0;
         end
      end else begin
         case (state)
            EMPTY, READY: begin
               if (capture) begin
                  w_reg    <= w_in;
                  w_loaded <= 1'b1;
                  sat_flag <= 1'b0;
                  state    <= READY;
               end else if (state == READY && z_valid) begin
                  z_reg <= z_in;
                  for (int i = 0; i < 4; i++) acc[i] <= '0;
                  k     <= '0;
                  state <= MAC;
               end
            end
            MAC: begin
               if (k == 3'd4) begin
                  y_reg   <= y_next;
                  y_valid <= 1'b1;
                  if (|clamp) sat_flag <= 1'b1;
                  state   <= OUT;
               end else begin
                  for (int i = 0; i < 4; i++) acc[i] <= acc[i] + AW'(prod[i]);
                  k <= k + 3'd1;
               end
            end
            OUT: begin
               if (y_ready) begin
                  y_valid <= 1'b0;
                  state   <= READY;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ica_unmix.sv
// Self-checking bench for ica_unmix: directed vector table, multi-cycle corner sequences,
// and randomized samples compared against an arithmetic model of y = sat(round(W*z)).
module tb_ica_unmix;

   localparam int DW = 26;
   localparam longint YMAXV = 33554431;
   localparam longint YMINV = -33554432;

   typedef logic signed [DW-1:0] vec4_t [4];
   typedef struct {
      int wsel;
      int zin[4];
      int yexp[4];
      bit sat;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstn, w_load, isConverge, z_valid, y_ready;
   logic signed [DW-1:0] w_m[4][4];
   vec4_t z_d;
   logic z_ready, y_valid, w_loaded, unmix_busy, sat_flag;
   logic signed [DW-1:0] y1, y2, y3, y4;

   int checks = 0;
   int errors = 0;
   longint exp_y[4];
   bit exp_sat;

   ica_unmix #(.DW(DW), .FRAC(20)) dut (
      .clk_unmix(clk), .rstn_unmix(rstn), .w_load(w_load), .isConverge(isConverge),
      .w11(w_m[0][0]), .w12(w_m[0][1]), .w13(w_m[0][2]), .w14(w_m[0][3]),
      .w21(w_m[1][0]), .w22(w_m[1][1]), .w23(w_m[1][2]), .w24(w_m[1][3]),
      .w31(w_m[2][0]), .w32(w_m[2][1]), .w33(w_m[2][2]), .w34(w_m[2][3]),
      .w41(w_m[3][0]), .w42(w_m[3][1]), .w43(w_m[3][2]), .w44(w_m[3][3]),
      .z_valid(z_valid), .z_ready(z_ready),
      .z1(z_d[0]), .z2(z_d[1]), .z3(z_d[2]), .z4(z_d[3]),
      .y_valid(y_valid), .y_ready(y_ready),
      .y1(y1), .y2(y2), .y3(y3), .y4(y4),
      .w_loaded(w_loaded), .unmix_busy(unmix_busy), .sat_flag(sat_flag)
   );

   task automatic checkOutput(input string name, input logic signed [63:0] act,
                              input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic checkY(input string tag, input longint e0, input longint e1,
                         input longint e2, input longint e3);
      checkOutput({tag, "_y1"}, y1, e0);
      checkOutput({tag, "_y2"}, y2, e1);
      checkOutput({tag, "_y3"}, y3, e2);
      checkOutput({tag, "_y4"}, y4, e3);
   endtask

   // Reference: exact integer dot product, round half up, arithmetic shift, clamp.
   function automatic void model(input vec4_t zz);
      longint acc, r;
      exp_sat = 1'b0;
      for (int i = 0; i < 4; i++) begin
         acc = 0;
         for (int j = 0; j < 4; j++) acc += longint'(w_m[i][j]) * longint'(zz[j]);
         r = (acc + 64'sd524288) >>> 20;
         if (r > YMAXV) begin r = YMAXV; exp_sat = 1'b1; end
         else if (r < YMINV) begin r = YMINV; exp_sat = 1'b1; end
         exp_y[i] = r;
      end
   endfunction

   task automatic set_w(input int wsel);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) w_m[i][j] = '0;
      case (wsel)
         0: for (int i = 0; i < 4; i++) w_m[i][i] = 26'sd1048576;
         1: begin w_m[0][0] = 26'sd524288; w_m[0][1] = 26'sd524288; end
         default: for (int j = 0; j < 4; j++) w_m[0][j] = 26'sd33554431;
      endcase
   endtask

   task automatic load_w();
      w_load = 1'b1; isConverge = 1'b1;
      @(posedge clk); #1;
      w_load = 1'b0;
   endtask

   task automatic applyStimulus(input vec4_t zz, output int lat);
      int n = 0;
      while (!z_ready && n < 50) begin @(posedge clk); #1; n++; end
      if (!z_ready) begin
         checkOutput("z_ready_timeout", z_ready, 1);
         lat = -1;
         return;
      end
      z_d = zz; z_valid = 1'b1;
      @(posedge clk); #1;
      z_valid = 1'b0;
      checkOutput("z_ready_fall", z_ready, 0);
      n = 0;
      while (!y_valid && n < 20) begin @(posedge clk); #1; n++; end
      lat = n;
   endtask

   task automatic releaseOutput();
      y_ready = 1'b1;
      @(posedge clk); #1;
      y_ready = 1'b0;
      checkOutput("y_valid_drop", y_valid, 0);
      checkOutput("z_ready_rise", z_ready, 1);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vec_t tbl[9];
      vec4_t zz;
      int lat, cur;
      logic signed [DW-1:0] hold_y;

      tbl[0] = '{0, '{100, -200, 300, -400}, '{100, -200, 300, -400}, 1'b0};
      tbl[1] = '{0, '{-5, 0, 7, 1048576},    '{-5, 0, 7, 1048576},    1'b0};
      tbl[2] = '{1, '{3, 0, 0, 0},           '{2, 0, 0, 0},           1'b0};
      tbl[3] = '{1, '{-3, 0, 0, 0},          '{-1, 0, 0, 0},          1'b0};
      tbl[4] = '{1, '{1, 2, 0, 0},           '{2, 0, 0, 0},           1'b0};
      tbl[5] = '{1, '{-1, 0, 0, 0},          '{0, 0, 0, 0},           1'b0};
      tbl[6] = '{2, '{33554431, 33554431, 33554431, 33554431}, '{33554431, 0, 0, 0}, 1'b1};
      tbl[7] = '{2, '{0, 0, 0, 0},           '{0, 0, 0, 0},           1'b1};
      tbl[8] = '{2, '{-33554431, -33554431, -33554431, -33554431}, '{-33554432, 0, 0, 0}, 1'b1};

      rstn = 1'b0; w_load = 1'b0; isConverge = 1'b0; z_valid = 1'b0; y_ready = 1'b0;
      for (int i = 0; i < 4; i++) z_d[i] = '0;
      set_w(0);
      #12;
      $display("[TB] checking reset state");
      checkOutput("rst_y_valid", y_valid, 0);
      checkOutput("rst_z_ready", z_ready, 0);
      checkOutput("rst_w_loaded", w_loaded, 0);
      checkOutput("rst_busy", unmix_busy, 0);
      checkOutput("rst_sat", sat_flag, 0);
      checkOutput("rst_y1", y1, 0);
      @(posedge clk); #1;
      rstn = 1'b1;

      // w_load without convergence must be ignored
      w_load = 1'b1; isConverge = 1'b0;
      @(posedge clk); #1;
      w_load = 1'b0;
      checkOutput("noconv_w_loaded", w_loaded, 0);
      checkOutput("noconv_z_ready", z_ready, 0);
      load_w();
      checkOutput("conv_z_ready", z_ready, 1);
      checkOutput("conv_w_loaded", w_loaded, 1);
      cur = 0;

      $display("[TB] directed vector table");
      for (int v = 0; v < 9; v++) begin
         if (tbl[v].wsel != cur) begin
            set_w(tbl[v].wsel);
            load_w();
            cur = tbl[v].wsel;
            checkOutput("load_sat_clear", sat_flag, 0);
         end
         for (int j = 0; j < 4; j++) zz[j] = DW'(tbl[v].zin[j]);
         applyStimulus(zz, lat);
         checkOutput("latency", lat, 5);
         checkY($sformatf("vec%0d", v), tbl[v].yexp[0], tbl[v].yexp[1],
                tbl[v].yexp[2], tbl[v].yexp[3]);
         checkOutput("vec_sat", sat_flag, tbl[v].sat);
         checkOutput("vec_busy", unmix_busy, 1);
         releaseOutput();
      end

      set_w(1);
      load_w();
      checkOutput("reload_sat_clear", sat_flag, 0);

      $display("[TB] backpressure with ignored w_load");
      set_w(0);
      load_w();
      zz = '{26'sd1234, -26'sd77, 26'sd0, 26'sd999};
      applyStimulus(zz, lat);
      checkOutput("bp_latency", lat, 5);
      hold_y = y1;
      set_w(1);
      w_load = 1'b1; isConverge = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         checkOutput("bp_y1_stable", y1, 1234);
         checkOutput("bp_y_valid", y_valid, 1);
         checkOutput("bp_z_ready", z_ready, 0);
      end
      w_load = 1'b0;
      checkOutput("bp_hold_match", y1, hold_y);
      releaseOutput();
      zz = '{26'sd11, 26'sd22, 26'sd33, 26'sd44};
      applyStimulus(zz, lat);
      checkY("bp_w_ignored", 11, 22, 33, 44);
      releaseOutput();

      $display("[TB] w_load and z_valid on the same edge");
      zz = '{26'sd1, 26'sd2, 26'sd0, 26'sd0};
      z_d = zz;
      w_load = 1'b1; isConverge = 1'b1; z_valid = 1'b1;
      @(posedge clk); #1;
      w_load = 1'b0; z_valid = 1'b0;
      checkOutput("same_edge_busy", unmix_busy, 0);
      checkOutput("same_edge_z_ready", z_ready, 1);
      applyStimulus(zz, lat);
      checkOutput("same_edge_latency", lat, 5);
      checkY("same_edge", 2, 0, 0, 0);
      releaseOutput();

      $display("[TB] reset during MAC");
      set_w(0);
      load_w();
      z_d = '{26'sd7, 26'sd8, 26'sd9, 26'sd10};
      z_valid = 1'b1;
      @(posedge clk); #1;
      z_valid = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b0;
      #1;
      checkOutput("abort_y_valid", y_valid, 0);
      checkOutput("abort_w_loaded", w_loaded, 0);
      checkOutput("abort_y1", y1, 0);
      checkOutput("abort_busy", unmix_busy, 0);
      @(posedge clk); #1;
      rstn = 1'b1;
      load_w();
      zz = '{26'sd50, 26'sd60, 26'sd70, 26'sd80};
      applyStimulus(zz, lat);
      checkOutput("abort_latency", lat, 5);
      checkY("after_abort", 50, 60, 70, 80);
      releaseOutput();

      $display("[TB] randomized samples against reference model");
      for (int r = 0; r < 24; r++) begin
         for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
               if (r % 4 == 3) w_m[i][j] = DW'($urandom);
               else w_m[i][j] = DW'(int'($urandom_range(0, 4194304)) - 2097152);
            end
         load_w();
         checkOutput("rnd_sat_clear", sat_flag, 0);
         for (int j = 0; j < 4; j++)
            zz[j] = DW'(int'($urandom_range(0, 33554432)) - 16777216);
         model(zz);
         applyStimulus(zz, lat);
         checkOutput("rnd_latency", lat, 5);
         checkY($sformatf("rnd%0d", r), exp_y[0], exp_y[1], exp_y[2], exp_y[3]);
         checkOutput("rnd_sat", sat_flag, exp_sat);
         releaseOutput();
      end

      $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
      $finish;
   end

endmodule
